imem_arbiter: RTL and testbench

- Shares the single-port, word-addressed instruction memory between two requesters: the fetch stage (read-only) and the program loader/debug port (read/write).
- Round-robin arbitration, with an optional loader lock for burst program loads.
- Handles byte-to-word address translation and flags misaligned or out-of-range accesses.
- Sits between the PC/fetch logic and instruction_mem. Memory has a 1-cycle synchronous read.

---
 rtl/imem_arbiter_if.sv | 56 +++++
 rtl/imem_arbiter.sv | 106 ++++++++++
 tb/tb_imem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - request/response and memory bus bundle for imem_arbiter
//
// Purpose: groups the fetch port, the loader port and the instruction-memory
// port of imem_arbiter into one bundle.
//   slave  modport: the arbiter side (takes requests, drives responses and memory).
//   master modport: the environment side (requesters plus memory).
// Port summary:
//   f_req_*  fetch read request (valid/ready/addr)
//   f_rsp_*  fetch response (valid/data/err), one cycle after acceptance
//   l_req_*  loader request (valid/ready/addr/we/wdata) plus l_lock
//   l_rsp_*  loader response/ack (valid/data/err)
//   mem_*    single-port memory: en/we/addr/wdata out, rdata in (1-cycle read)
interface imem_arbiter_if #(
  parameter int AW = 8
);
  logic          f_req_valid;
  logic          f_req_ready;
  logic [31:0]   f_req_addr;
  logic          f_rsp_valid;
  logic [31:0]   f_rsp_data;
  logic          f_rsp_err;

  logic          l_req_valid;
  logic          l_req_ready;
  logic [31:0]   l_req_addr;
  logic          l_req_we;
  logic [31:0]   l_req_wdata;
  logic          l_lock;
  logic          l_rsp_valid;
  logic [31:0]   l_rsp_data;
  logic          l_rsp_err;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  f_req_valid, f_req_addr,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    input  l_req_valid, l_req_addr, l_req_we, l_req_wdata, l_lock,
    output l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output f_req_valid, f_req_addr,
    input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    output l_req_valid, l_req_addr, l_req_we, l_req_wdata, l_lock,
    input  l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - round-robin fetch/loader arbiter for the instruction memory
//
// Purpose: shares a single-port, word-addressed instruction memory between the
// fetch stage (read-only) and the loader/debug port (read/write). Round-robin
// arbitration, optional loader lock for burst loads, byte-to-word translation
// and misaligned/out-of-range error flagging.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    imem_arbiter_if.slave: fetch port, loader port, memory port
module imem_arbiter #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  imem_arbiter_if.slave bus
);

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  // Highest legal word index + 1, as a 30-bit word address.
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t state_q;
  logic   last_l_q;   // last accepted request came from the loader
  logic   f_pend_q;   // fetch response due this cycle
  logic   l_pend_q;   // loader response due this cycle
  logic   err_q;      // pending response is an address error
  logic   wr_q;       // pending response acknowledges a write

  logic f_err, l_err, ptr_l;
  logic f_gnt, l_gnt, f_fwd, l_fwd, rd_ok;

  assign f_err = (bus.f_req_addr[1:0] != 2'b00) || (bus.f_req_addr[31:2] >= DEPTH_W);
  assign l_err = (bus.l_req_addr[1:0] != 2'b00) || (bus.l_req_addr[31:2] >= DEPTH_W);

  // The cycle that releases a lock arbitrates as if the loader went last.
  assign ptr_l = last_l_q || (state_q == LOCK);

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!reset) begin
      if (state_q == LOCK && bus.l_lock) begin
        l_gnt = bus.l_req_valid;
      end else if (bus.f_req_valid && bus.l_req_valid) begin
        f_gnt = ptr_l;
        l_gnt = !ptr_l;
      end else begin
        f_gnt = bus.f_req_valid;
        l_gnt = bus.l_req_valid;
      end
    end
  end

  // Erroring requests are accepted but never reach the memory.
  assign f_fwd = f_gnt && !f_err;
  assign l_fwd = l_gnt && !l_err;

  assign bus.f_req_ready = f_gnt;
  assign bus.l_req_ready = l_gnt;

  assign bus.mem_en    = f_fwd || l_fwd;
  assign bus.mem_we    = l_fwd && bus.l_req_we;
  assign bus.mem_addr  = f_fwd ? bus.f_req_addr[AW+1:2] :
                         (l_fwd ? bus.l_req_addr[AW+1:2] : '0);
  assign bus.mem_wdata = (l_fwd && bus.l_req_we) ? bus.l_req_wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB;
      last_l_q <= 1'b1;
      f_pend_q <= 1'b0;
      l_pend_q <= 1'b0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      f_pend_q <= f_gnt;
      l_pend_q <= l_gnt;
      err_q    <= (f_gnt && f_err) || (l_gnt && l_err);
      wr_q     <= l_gnt && bus.l_req_we;
      if (f_gnt) begin
        last_l_q <= 1'b0;
      end else if (l_gnt) begin
        last_l_q <= 1'b1;
      end
      case (state_q)
        ARB:  if (l_gnt && bus.l_lock) state_q <= LOCK;
        LOCK: if (!bus.l_lock)         state_q <= ARB;
      endcase
    end
  end

  // Only one grant per cycle, so the error/write flags are shared by both ports.
  assign rd_ok = !err_q && !wr_q;

  assign bus.f_rsp_valid = f_pend_q;
  assign bus.f_rsp_err   = f_pend_q && err_q;
  assign bus.f_rsp_data  = (f_pend_q && rd_ok) ? bus.mem_rdata : '0;

  assign bus.l_rsp_valid = l_pend_q;
  assign bus.l_rsp_err   = l_pend_q && err_q;
  assign bus.l_rsp_data  = (l_pend_q && rd_ok) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - self-checking bench for imem_arbiter
module tb_imem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_arbiter_if #(.AW(8)) bus ();

  imem_arbiter #(.DEPTH(256), .AW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Memory with a 1-cycle synchronous read; contents restored on reset.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check1(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_bad(logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024);
  endfunction

  // Reference model: ownership, last-grant and expected responses.
  logic [31:0] ref_mem [0:255];
  bit          m_locked, m_last_l;
  logic        ef_v, ef_e, el_v, el_e;
  logic [31:0] ef_d, el_d;
  logic        gf, gl, bad, e_en, e_we;
  logic [31:0] a;
  int          idx;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check1("rst_f_ready", bus.f_req_ready, 1'b0);
        check1("rst_l_ready", bus.l_req_ready, 1'b0);
        check1("rst_mem_en", bus.mem_en, 1'b0);
        check1("rst_f_rsp_valid", bus.f_rsp_valid, 1'b0);
        check1("rst_l_rsp_valid", bus.l_rsp_valid, 1'b0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA000_0000 + 32'(i);
        m_locked = 1'b0;
        m_last_l = 1'b1;
        ef_v = 1'b0; ef_e = 1'b0; ef_d = '0;
        el_v = 1'b0; el_e = 1'b0; el_d = '0;
      end else begin
        gf = 1'b0;
        gl = 1'b0;
        if (m_locked && bus.l_lock) begin
          gl = bus.l_req_valid;
        end else if (bus.f_req_valid && bus.l_req_valid) begin
          gf = m_last_l;
          gl = !m_last_l;
        end else begin
          gf = bus.f_req_valid;
          gl = bus.l_req_valid;
        end
        a    = gf ? bus.f_req_addr : bus.l_req_addr;
        bad  = addr_bad(a);
        idx  = bad ? 0 : int'(a / 4);
        e_en = (gf || gl) && !bad;
        e_we = e_en && gl && bus.l_req_we;

        check1("f_req_ready", bus.f_req_ready, gf);
        check1("l_req_ready", bus.l_req_ready, gl);
        check1("mem_en", bus.mem_en, e_en);
        check1("mem_we", bus.mem_we, e_we);
        check32("mem_addr", 32'(bus.mem_addr), e_en ? 32'(idx) : 32'd0);
        check32("mem_wdata", bus.mem_wdata, e_we ? bus.l_req_wdata : 32'd0);

        check1("f_rsp_valid", bus.f_rsp_valid, ef_v);
        check1("f_rsp_err", bus.f_rsp_err, ef_e);
        check32("f_rsp_data", bus.f_rsp_data, ef_d);
        check1("l_rsp_valid", bus.l_rsp_valid, el_v);
        check1("l_rsp_err", bus.l_rsp_err, el_e);
        check32("l_rsp_data", bus.l_rsp_data, el_d);

        ef_v = gf;
        ef_e = gf && bad;
        ef_d = (gf && !bad) ? ref_mem[idx] : 32'd0;
        el_v = gl;
        el_e = gl && bad;
        el_d = (gl && !bad && !bus.l_req_we) ? ref_mem[idx] : 32'd0;
        if (e_we) ref_mem[idx] = bus.l_req_wdata;

        m_locked = (gl && bus.l_lock) || (m_locked && bus.l_lock);
        if (gf)      m_last_l = 1'b0;
        else if (gl) m_last_l = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.f_req_valid = 1'b0;
    bus.f_req_addr  = '0;
    bus.l_req_valid = 1'b0;
    bus.l_req_addr  = '0;
    bus.l_req_we    = 1'b0;
    bus.l_req_wdata = '0;
    bus.l_lock      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
    if (r == 1) return $urandom | 32'h400;
    if (r == 2) return 32'h3FC;
    return 32'($urandom_range(0, 31)) << 2;
  endfunction

  int  k, acks;
  logic acc, fa, la;

  initial begin
    clear_inputs();
    reset = 1'b1;
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 32'h8;
    repeat (2) @(posedge clk);
    #3;
    check1("reset_f_ready", bus.f_req_ready, 1'b0);
    check1("reset_mem_en", bus.mem_en, 1'b0);
    check1("reset_f_rsp", bus.f_rsp_valid, 1'b0);
    check1("reset_l_rsp", bus.l_rsp_valid, 1'b0);

    // Single fetch
    step();
    reset = 1'b0;
    #1;
    check1("single_ready", bus.f_req_ready, 1'b1);
    check1("single_mem_en", bus.mem_en, 1'b1);
    check1("single_mem_we", bus.mem_we, 1'b0);
    check32("single_mem_addr", 32'(bus.mem_addr), 32'd2);
    step();
    bus.f_req_valid = 1'b0;
    #1;
    check1("single_rsp_valid", bus.f_rsp_valid, 1'b1);
    check32("single_rsp_data", bus.f_rsp_data, 32'hA000_0002);
    check1("single_rsp_err", bus.f_rsp_err, 1'b0);

    // Contention: F,L,F,L,F,L
    do_reset();
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 32'h8;
    bus.l_req_valid = 1'b1;
    bus.l_req_addr  = 32'h10;
    for (int i = 0; i < 6; i++) begin
      #1;
      check1("cont_f_ready", bus.f_req_ready, (i % 2) == 0);
      check1("cont_l_ready", bus.l_req_ready, (i % 2) == 1);
      if (i >= 1) begin
        check1("cont_f_rsp", bus.f_rsp_valid, (i % 2) == 1);
        check1("cont_l_rsp", bus.l_rsp_valid, (i % 2) == 0);
        if (i % 2 == 0) check32("cont_l_data", bus.l_rsp_data, 32'hA000_0004);
      end
      step();
    end
    clear_inputs();
    #1;
    check1("cont_last_l_rsp", bus.l_rsp_valid, 1'b1);
    check32("cont_last_l_data", bus.l_rsp_data, 32'hA000_0004);

    // Locked burst load while fetch waits on address 0
    do_reset();
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 32'h0;
    bus.l_req_valid = 1'b1;
    bus.l_req_we    = 1'b1;
    bus.l_lock      = 1'b1;
    bus.l_req_addr  = 32'h0;
    bus.l_req_wdata = 32'h1111_1111;
    k = 0;
    acks = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      #1;
      if (bus.l_rsp_valid) acks++;
      if (k >= 1) check1("lock_fetch_blocked", bus.f_req_ready, 1'b0);
      acc = bus.l_req_ready;
      step();
      if (acc) begin
        k++;
        if (k < 3) begin
          bus.l_req_addr  = 32'(k * 4);
          bus.l_req_wdata = 32'h1111_1111 * 32'(k + 1);
        end else begin
          bus.l_req_valid = 1'b0;
          bus.l_req_we    = 1'b0;
          bus.l_lock      = 1'b0;
        end
      end
    end
    check32("lock_writes_accepted", 32'(k), 32'd3);
    #1;
    if (bus.l_rsp_valid) acks++;
    check1("lock_release_fetch", bus.f_req_ready, 1'b1);
    check32("lock_acks", 32'(acks), 32'd3);
    step();
    bus.f_req_valid = 1'b0;
    #1;
    check32("lock_fetch_newdata", bus.f_rsp_data, 32'h1111_1111);

    // Misaligned fetch
    step();
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 32'h6;
    #1;
    check1("misal_ready", bus.f_req_ready, 1'b1);
    check1("misal_mem_en", bus.mem_en, 1'b0);
    step();
    bus.f_req_valid = 1'b0;
    #1;
    check1("misal_rsp_valid", bus.f_rsp_valid, 1'b1);
    check1("misal_rsp_err", bus.f_rsp_err, 1'b1);
    check32("misal_rsp_data", bus.f_rsp_data, 32'h0);

    // Out of range, then last legal word
    step();
    bus.l_req_valid = 1'b1;
    bus.l_req_addr  = 32'h400;
    #1;
    check1("oor_ready", bus.l_req_ready, 1'b1);
    check1("oor_mem_en", bus.mem_en, 1'b0);
    step();
    bus.l_req_addr = 32'h3FC;
    #1;
    check1("oor_rsp_err", bus.l_rsp_err, 1'b1);
    check1("top_mem_en", bus.mem_en, 1'b1);
    check32("top_mem_addr", 32'(bus.mem_addr), 32'd255);
    step();
    bus.l_req_valid = 1'b0;
    #1;
    check1("top_rsp_err", bus.l_rsp_err, 1'b0);
    check32("top_rsp_data", bus.l_rsp_data, 32'hA000_00FF);

    // Reset mid-operation
    step();
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 32'h8;
    step();
    #1;
    check1("mid_rsp_before", bus.f_rsp_valid, 1'b1);
    reset = 1'b1;
    #1;
    check1("mid_rsp_dropped", bus.f_rsp_valid, 1'b0);
    check1("mid_ready_zero", bus.f_req_ready, 1'b0);
    check1("mid_mem_en_zero", bus.mem_en, 1'b0);
    bus.f_req_valid = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check1("mid_no_rsp", bus.f_rsp_valid, 1'b0);
      step();
    end
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 32'h8;
    bus.l_req_valid = 1'b1;
    bus.l_req_addr  = 32'h10;
    #1;
    check1("mid_first_f", bus.f_req_ready, 1'b1);
    check1("mid_first_l", bus.l_req_ready, 1'b0);
    step();
    clear_inputs();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      #1;
      fa = bus.f_req_valid && bus.f_req_ready;
      la = bus.l_req_valid && bus.l_req_ready;
      step();
      if (!bus.f_req_valid || fa) begin
        bus.f_req_valid = ($urandom_range(0, 3) != 0);
        bus.f_req_addr  = pick_addr();
      end
      if (!bus.l_req_valid || la) begin
        bus.l_req_valid = ($urandom_range(0, 2) != 0);
        bus.l_req_we    = $urandom_range(0, 1) == 1;
        bus.l_req_wdata = $urandom;
        bus.l_req_addr  = pick_addr();
      end
      bus.l_lock = ($urandom_range(0, 7) == 0) || (bus.l_lock && $urandom_range(0, 5) != 0);
    end

    clear_inputs();
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
